list_sum_engine: RTL and testbench



---
 rtl/list_sum_pkg.sv | 16 +
 rtl/list_sum_acc.sv | 38 +++
 rtl/list_sum_engine.sv | 109 ++++++++++
 tb/tb_list_sum_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/list_sum_pkg.sv
// Shared constants for the linked-list summation engine: FSM state encoding,
// node layout offsets and the list terminator address.
package list_sum_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_VAL = 3'd1;
  localparam logic [2:0] S_FETCH_PTR = 3'd2;
  localparam logic [2:0] S_LINK      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  // A node occupies two consecutive words: value first, then next-pointer.
  localparam int VAL_OFS  = 0;
  localparam int PTR_OFS  = 1;
  localparam int NIL_ADDR = 0;

endpackage

// File: rtl/list_sum_acc.sv
// Sum accumulator with synchronous clear, add enable, wrap or saturate mode
// and a sticky carry-out flag.
module list_sum_acc #(
  parameter int DATA_W = 32,
  parameter int SAT_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] sum,
  output logic              overflow
);

  logic [DATA_W:0] total;

  assign total = {1'b0, sum} + {1'b0, value};

  // Once saturated the sum is all-ones, so any further non-zero add carries
  // again and adding zero leaves it unchanged: saturation holds by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else if (add_en) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples values from before this edge, independent of statement order.
      overflow <= overflow | total[DATA_W];
      if ((SAT_EN != 0) && total[DATA_W]) sum <= '1;
      else                                sum <= total[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/list_sum_engine.sv
// Walks a singly linked list in synchronous-read memory and reports the sum of
// node values, the node count and overflow / traversal-limit flags.
module list_sum_engine
  import list_sum_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MAX_NODES = 255,
  parameter int SAT_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum_out,
  output logic [ADDR_W:0]   node_cnt,
  output logic              overflow,
  output logic              err_limit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] ptr;
  logic              accept;

  assign ptr    = mem_rdata[ADDR_W-1:0];
  assign accept = (state == S_IDLE) && start;

  list_sum_acc #(
    .DATA_W (DATA_W),
    .SAT_EN (SAT_EN)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .add_en   (state == S_FETCH_PTR),
    .value    (mem_rdata),
    .sum      (sum_out),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur       <= '0;
      node_cnt  <= '0;
      err_limit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur       <= head_addr;
            node_cnt  <= '0;
            err_limit <= 1'b0;
            state     <= (head_addr == ADDR_W'(NIL_ADDR)) ? S_DONE : S_FETCH_VAL;
          end
        end
        S_FETCH_VAL: state <= S_FETCH_PTR;
        S_FETCH_PTR: begin
          node_cnt <= node_cnt + 1'b1;
          state    <= S_LINK;
        end
        S_LINK: begin
          // node_cnt already includes the node whose pointer is on mem_rdata.
          if (ptr == ADDR_W'(NIL_ADDR)) begin
            state <= S_DONE;
          end else if (node_cnt == (ADDR_W+1)'(MAX_NODES)) begin
            err_limit <= 1'b1;
            state     <= S_DONE;
          end else begin
            cur   <= ptr;
            state <= S_FETCH_VAL;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state)
      S_FETCH_VAL: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = cur + ADDR_W'(VAL_OFS);
      end
      S_FETCH_PTR: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = cur + ADDR_W'(PTR_OFS);
      end
      S_LINK:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_list_sum_engine.sv
// Directed bench for list_sum_engine: four instances (default, 8-bit wrap,
// 8-bit saturate, MAX_NODES=5) sharing one behavioural memory image.
module tb_list_sum_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       start_v  = '0;
  logic [3:0][7:0]  head_v   = '0;
  logic [3:0]       done_v, busy_v, ovf_v, err_v, mem_rd_v;
  logic [3:0][7:0]  mem_addr_v;
  logic [3:0][8:0]  cnt_v;
  logic [31:0]      sum_v  [4];
  logic [31:0]      rdata_v[4];
  logic [31:0]      sum0;
  logic [7:0]       sum1, sum2;
  logic [31:0]      sum3;
  logic [31:0]      mem [256];

  assign sum_v[0] = sum0;
  assign sum_v[1] = {24'd0, sum1};
  assign sum_v[2] = {24'd0, sum2};
  assign sum_v[3] = sum3;

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_rd_v[i]) rdata_v[i] <= mem[mem_addr_v[i]];

  list_sum_engine u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .head_addr(head_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum_out(sum0), .node_cnt(cnt_v[0]),
    .overflow(ovf_v[0]), .err_limit(err_v[0]), .mem_addr(mem_addr_v[0]),
    .mem_rd(mem_rd_v[0]), .mem_rdata(rdata_v[0]));

  list_sum_engine #(.DATA_W(8), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start_v[1]), .head_addr(head_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum_out(sum1), .node_cnt(cnt_v[1]),
    .overflow(ovf_v[1]), .err_limit(err_v[1]), .mem_addr(mem_addr_v[1]),
    .mem_rd(mem_rd_v[1]), .mem_rdata(rdata_v[1][7:0]));

  list_sum_engine #(.DATA_W(8), .SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .start(start_v[2]), .head_addr(head_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum_out(sum2), .node_cnt(cnt_v[2]),
    .overflow(ovf_v[2]), .err_limit(err_v[2]), .mem_addr(mem_addr_v[2]),
    .mem_rd(mem_rd_v[2]), .mem_rdata(rdata_v[2][7:0]));

  list_sum_engine #(.MAX_NODES(5)) u_lim (
    .clk(clk), .rst(rst), .start(start_v[3]), .head_addr(head_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .sum_out(sum3), .node_cnt(cnt_v[3]),
    .overflow(ovf_v[3]), .err_limit(err_v[3]), .mem_addr(mem_addr_v[3]),
    .mem_rd(mem_rd_v[3]), .mem_rdata(rdata_v[3]));

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [7:0] addr_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents start for one edge (the cycle-0 sample); leaves it high if hold.
  task automatic go(input int s, input logic [7:0] h, input bit hold);
    addr_q.delete();
    @(negedge clk);
    start_v[s] = 1'b1;
    head_v[s]  = h;
    @(posedge clk);
    #1;
    if (!hold) start_v[s] = 1'b0;
  endtask

  // Called in cycle 1 of a traversal; returns the cycle in which done is seen.
  task automatic wait_done(input int s, output int c);
    c = 1;
    while (!done_v[s] && c < 400) begin
      if (mem_rd_v[s]) addr_q.push_back(mem_addr_v[s]);
      @(posedge clk);
      #1;
      c++;
    end
    check("done_seen", done_v[s], 1'b1);
  endtask

  task automatic load_list1();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 10; mem[5] = 8; mem[8] = 20; mem[9] = 12; mem[12] = 30; mem[13] = 0;
  endtask

  initial begin
    load_list1();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum",  sum_v[0], 0);
    check("rst_cnt",  cnt_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_rd",   mem_rd_v[0], 0);
    check("rst_addr", mem_addr_v[0], 0);
    check("rst_ovf",  ovf_v[0], 0);
    check("rst_err",  err_v[0], 0);
    rst = 1'b0;

    // Three-node list 10 + 20 + 30.
    go(0, 8'd4, 1'b0);
    wait_done(0, cyc);
    check("l1_cycle", cyc, 10);
    check("l1_sum",   sum_v[0], 60);
    check("l1_cnt",   cnt_v[0], 3);
    check("l1_ovf",   ovf_v[0], 0);
    check("l1_err",   err_v[0], 0);
    check("l1_nrd",   addr_q.size(), 6);
    if (addr_q.size() == 6) begin
      check("l1_a0", addr_q[0], 4);
      check("l1_a1", addr_q[1], 5);
      check("l1_a2", addr_q[2], 8);
      check("l1_a3", addr_q[3], 9);
      check("l1_a4", addr_q[4], 12);
      check("l1_a5", addr_q[5], 13);
    end
    @(posedge clk);
    #1;
    check("l1_done_pulse", done_v[0], 0);
    check("l1_hold_sum",   sum_v[0], 60);

    // Empty list.
    go(0, 8'd0, 1'b0);
    wait_done(0, cyc);
    check("nil_cycle", cyc, 1);
    check("nil_sum",   sum_v[0], 0);
    check("nil_cnt",   cnt_v[0], 0);
    check("nil_nrd",   addr_q.size(), 0);
    @(posedge clk);

    // 8-bit datapath: 200 + 100 wraps to 44 or saturates to 255.
    mem[4] = 200; mem[5] = 8; mem[8] = 100; mem[9] = 0;
    go(1, 8'd4, 1'b0);
    wait_done(1, cyc);
    check("wrap_cycle", cyc, 7);
    check("wrap_sum",   sum_v[1], 44);
    check("wrap_ovf",   ovf_v[1], 1);
    check("wrap_cnt",   cnt_v[1], 2);
    @(posedge clk);
    go(2, 8'd4, 1'b0);
    wait_done(2, cyc);
    check("sat_sum", sum_v[2], 255);
    check("sat_ovf", ovf_v[2], 1);
    @(posedge clk);

    // Self-loop stopped by MAX_NODES=5.
    mem[4] = 1; mem[5] = 4;
    go(3, 8'd4, 1'b0);
    wait_done(3, cyc);
    check("lim_cycle", cyc, 16);
    check("lim_sum",   sum_v[3], 5);
    check("lim_cnt",   cnt_v[3], 5);
    check("lim_err",   err_v[3], 1);
    @(posedge clk);

    // Reset mid-traversal, then a clean rerun.
    load_list1();
    go(0, 8'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy_before", busy_v[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", busy_v[0], 0);
    check("mid_rst_rd",   mem_rd_v[0], 0);
    check("mid_rst_sum",  sum_v[0], 0);
    check("mid_rst_cnt",  cnt_v[0], 0);
    check("mid_rst_done", done_v[0], 0);
    rst = 1'b0;
    go(0, 8'd4, 1'b0);
    wait_done(0, cyc);
    check("rerun_cycle", cyc, 10);
    check("rerun_sum",   sum_v[0], 60);
    @(posedge clk);

    // start held high: ignored while busy, re-accepted in the IDLE after done.
    go(0, 8'd4, 1'b1);
    wait_done(0, cyc);
    check("hold_cycle", cyc, 10);
    check("hold_sum",   sum_v[0], 60);
    @(posedge clk);
    #1;
    check("hold_idle_busy", busy_v[0], 0);
    check("hold_idle_sum",  sum_v[0], 60);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("hold_restart_busy", busy_v[0], 1);
    check("hold_restart_sum",  sum_v[0], 0);
    check("hold_restart_cnt",  cnt_v[0], 0);
    addr_q.delete();
    wait_done(0, cyc);
    check("hold2_cycle", cyc, 10);
    check("hold2_sum",   sum_v[0], 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
